fir_mac_engine: RTL and testbench

FIR_MAC_ENGINE -- requirements
Module: fir_mac_engine

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_round_sat.sv | 41 ++++
 rtl/fir_mac_engine.sv | 110 +++++++++++
 tb/tb_fir_mac_engine.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FSM encoding and width helpers for the FIR MAC engine.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Headroom of clog2(taps) bits lets the sum of all products grow without wrapping.
  function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
    return data_w + coeff_w + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Rounds (half-up) and arithmetically shifts the accumulator, then clamps it to the output range.
module fir_round_sat #(
  parameter int ACC_W     = 37,
  parameter int DATA_W    = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] result,
  output logic                     sat
);

  // One spare bit so adding the rounding constant can never wrap.
  localparam int EXT_W = ACC_W + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [EXT_W-1:0] scaled;

  generate
    if (OUT_SHIFT > 0) begin : g_round
      localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (OUT_SHIFT - 1);
      assign scaled = ($signed({acc[ACC_W-1], acc}) + HALF) >>> OUT_SHIFT;
    end else begin : g_pass
      assign scaled = $signed({acc[ACC_W-1], acc});
    end
  endgenerate

  // NOTE: every output gets a default first so no path through the block can infer a latch.
  always_comb begin
    sat    = 1'b0;
    result = scaled[DATA_W-1:0];
    if (scaled > MAX_V) begin
      result = MAX_V[DATA_W-1:0];
      sat    = 1'b1;
    end else if (scaled < MIN_V) begin
      result = MIN_V[DATA_W-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/fir_mac_engine.sv
// Sequential single-multiplier FIR: one tap per cycle, then a held result with valid/ready handshake.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter  int TAPS      = 32,
  parameter  int DATA_W    = 16,
  parameter  int COEFF_W   = 16,
  parameter  int OUT_SHIFT = 0,
  localparam int IDX_W     = clog2(TAPS),
  localparam int ACC_W     = acc_width(DATA_W, COEFF_W, TAPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_sample,
  output logic               in_ready,
  input  logic               coeff_wr_en,
  input  logic [IDX_W-1:0]   coeff_addr,
  input  logic [COEFF_W-1:0] coeff_wr_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_sample,
  output logic               busy,
  output logic               sat_flag
);

  localparam int PROD_W = DATA_W + COEFF_W;

  state_t                    state;
  logic signed [DATA_W-1:0]  delay_line [TAPS];
  logic signed [COEFF_W-1:0] coeff      [TAPS];
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [PROD_W-1:0]  prod;
  logic [IDX_W-1:0]          idx;
  logic [DATA_W-1:0]         rs_result;
  logic                      rs_sat;
  logic                      last_mac;
  logic                      addr_ok;

  assign prod     = PROD_W'(coeff[idx]) * PROD_W'(delay_line[idx]);
  assign acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign last_mac = (idx == IDX_W'(TAPS - 1));
  assign addr_ok  = (32'(coeff_addr) < TAPS);

  // Rounding sees the sum including the final product, so out_sample loads on the OUT-entry edge.
  fir_round_sat #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_round_sat (
    .acc   (acc_next),
    .result(rs_result),
    .sat   (rs_sat)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      sat_flag   <= 1'b0;
      acc        <= '0;
      idx        <= '0;
      // NOTE: the coefficient and delay-line arrays must clear on reset, so they stay flops, not RAM.
      for (int k = 0; k < TAPS; k++) begin
        delay_line[k] <= '0;
        coeff[k]      <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (coeff_wr_en && addr_ok) coeff[coeff_addr] <= coeff_wr_data;
          if (in_valid) begin
            delay_line[0] <= in_sample;
            for (int k = 1; k < TAPS; k++) delay_line[k] <= delay_line[k-1];
            acc      <= '0;
            idx      <= '0;
            state    <= MAC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc_next;
          idx <= idx + 1'b1;
          if (last_mac) begin
            state      <= OUT;
            out_valid  <= 1'b1;
            out_sample <= rs_result;
            if (rs_sat) sat_flag <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed and randomized checks of fir_mac_engine against a sum-of-products reference model.
module tb_fir_mac_engine;

  localparam int TAPS = 32;
  localparam int RT   = 4;

  logic        clk = 1'b0;
  logic        rst, rst_r;
  logic        in_valid, in_ready, coeff_wr_en, out_valid, out_ready, busy, sat_flag;
  logic [15:0] in_sample, coeff_wr_data, out_sample;
  logic [4:0]  coeff_addr;

  logic        r_in_valid, r_in_ready, r_coeff_wr_en, r_out_valid, r_out_ready, r_busy, r_sat_flag;
  logic [15:0] r_in_sample, r_coeff_wr_data, r_out_sample;
  logic [1:0]  r_coeff_addr;

  int     n_total = 0;
  int     n_fail  = 0;
  longint hist   [TAPS];
  longint coef_m [TAPS];
  bit     sat_m;
  logic [15:0] got;
  bit          wr, seen;

  always #5 clk = ~clk;

  fir_mac_engine dut (
    .clk(clk), .reset(rst), .in_valid(in_valid), .in_sample(in_sample), .in_ready(in_ready),
    .coeff_wr_en(coeff_wr_en), .coeff_addr(coeff_addr), .coeff_wr_data(coeff_wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .busy(busy), .sat_flag(sat_flag)
  );

  fir_mac_engine #(.TAPS(RT), .OUT_SHIFT(1)) dut_r (
    .clk(clk), .reset(rst_r), .in_valid(r_in_valid), .in_sample(r_in_sample), .in_ready(r_in_ready),
    .coeff_wr_en(r_coeff_wr_en), .coeff_addr(r_coeff_addr), .coeff_wr_data(r_coeff_wr_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_sample(r_out_sample),
    .busy(r_busy), .sat_flag(r_sat_flag)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coeff(input logic [4:0] a, input logic [15:0] d);
    coeff_wr_en = 1'b1; coeff_addr = a; coeff_wr_data = d;
    tick();
    coeff_wr_en = 1'b0;
    coef_m[a] = longint'($signed(d));
  endtask

  // Offers one sample, checks latency, result and sticky flag; optional MAC-time writes and backpressure.
  task automatic run_sample(input logic [15:0] s, input bit same_wr, input logic [4:0] a,
                            input logic [15:0] d, input bit mac_wr, input int hold,
                            input string tag, output logic [15:0] obs);
    longint      v;
    logic [15:0] exp;
    bit          early, stable;
    in_valid = 1'b1; in_sample = s;
    if (same_wr) begin coeff_wr_en = 1'b1; coeff_addr = a; coeff_wr_data = d; end
    tick();
    in_valid = 1'b0; coeff_wr_en = 1'b0;
    if (same_wr) coef_m[a] = longint'($signed(d));
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'($signed(s));
    v = 0;
    for (int k = 0; k < TAPS; k++) v += coef_m[k] * hist[k];
    if (v > 32767) begin v = 32767; sat_m = 1'b1; end
    else if (v < -32768) begin v = -32768; sat_m = 1'b1; end
    exp = 16'(v);
    check({tag, "_busy"}, {busy, in_ready}, 2'b10);
    if (mac_wr) begin coeff_wr_en = 1'b1; coeff_addr = 5'd0; coeff_wr_data = 16'd5; end
    early = 1'b0;
    for (int i = 0; i < TAPS; i++) begin
      if (out_valid !== 1'b0) early = 1'b1;
      tick();
    end
    check({tag, "_early_valid"}, early, 1'b0);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_out"}, out_sample, exp);
    check({tag, "_sat"}, sat_flag, sat_m);
    obs = out_sample;
    if (hold > 0) begin
      stable = 1'b1;
      in_valid = 1'b1; in_sample = 16'h1234;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (!(out_valid === 1'b1 && out_sample === exp && in_ready === 1'b0)) stable = 1'b0;
      end
      in_valid = 1'b0;
      check({tag, "_hold_stable"}, stable, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; coeff_wr_en = 1'b0;
    if (hold > 0) check({tag, "_back_idle"}, {in_ready, out_valid, busy}, 3'b100);
  endtask

  task automatic run_r(input logic [15:0] s, input logic [15:0] exp, input string tag);
    r_in_valid = 1'b1; r_in_sample = s;
    tick();
    r_in_valid = 1'b0;
    repeat (RT) tick();
    check({tag, "_valid"}, r_out_valid, 1'b1);
    check({tag, "_out"}, r_out_sample, exp);
    r_out_ready = 1'b1;
    tick();
    r_out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst_r = 1'b1;
    in_valid = 1'b0; in_sample = '0; coeff_wr_en = 1'b0; coeff_addr = '0; coeff_wr_data = '0; out_ready = 1'b0;
    r_in_valid = 1'b0; r_in_sample = '0; r_coeff_wr_en = 1'b0; r_coeff_addr = '0; r_coeff_wr_data = '0;
    r_out_ready = 1'b0;
    for (int k = 0; k < TAPS; k++) begin hist[k] = 0; coef_m[k] = 0; end
    sat_m = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sat", sat_flag, 1'b0);
    check("rst_out_sample", out_sample, 16'h0000);
    rst = 1'b0; rst_r = 1'b0;
    tick();

    // Impulse response with coeff[k] = k+1.
    for (int k = 0; k < TAPS; k++) write_coeff(5'(k), 16'(k + 1));
    for (int n = 0; n <= TAPS; n++) begin
      run_sample((n == 0) ? 16'd1 : 16'd0, 1'b0, '0, '0, 1'b0, 0, $sformatf("imp%0d", n), got);
      check($sformatf("imp%0d_const", n), got, (n < TAPS) ? 16'(n + 1) : 16'd0);
    end

    run_sample(16'd9, 1'b0, '0, '0, 1'b0, 10, "backpressure", got);
    run_sample(16'd7, 1'b0, '0, '0, 1'b1, 0, "mac_write", got);
    run_sample(16'd3, 1'b0, '0, '0, 1'b0, 0, "after_mac_write", got);

    // Random small coefficients and samples; some writes coincide with sample acceptance.
    for (int k = 0; k < TAPS; k++) write_coeff(5'(k), 16'(int'($urandom_range(0, 63)) - 32));
    for (int n = 0; n < 20; n++) begin
      wr = ($urandom_range(0, 3) == 0);
      run_sample(16'(int'($urandom_range(0, 63)) - 32), wr, 5'($urandom_range(0, 31)),
                 16'(int'($urandom_range(0, 63)) - 32), 1'b0, 0, $sformatf("rnd%0d", n), got);
    end

    // Saturation at both extremes.
    for (int k = 0; k < TAPS; k++) write_coeff(5'(k), 16'h7FFF);
    for (int n = 0; n < TAPS; n++) run_sample(16'h7FFF, 1'b0, '0, '0, 1'b0, 0, $sformatf("satp%0d", n), got);
    check("sat_pos_const", got, 16'h7FFF);
    check("sat_pos_flag", sat_flag, 1'b1);
    for (int n = 0; n < TAPS; n++) run_sample(16'h8000, 1'b0, '0, '0, 1'b0, 0, $sformatf("satn%0d", n), got);
    check("sat_neg_const", got, 16'h8000);

    // Reset in the middle of a MAC pass.
    in_valid = 1'b1; in_sample = 16'd1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_async", {out_valid, in_ready, busy}, 3'b010);
    tick();
    rst = 1'b0;
    for (int k = 0; k < TAPS; k++) begin hist[k] = 0; coef_m[k] = 0; end
    sat_m = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < TAPS + 4; i++) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    for (int n = 0; n < 3; n++) begin
      run_sample((n == 0) ? 16'd1 : 16'd0, 1'b0, '0, '0, 1'b0, 0, $sformatf("postrst%0d", n), got);
      check($sformatf("postrst%0d_const", n), got, 16'd0);
    end

    // Half-up rounding with OUT_SHIFT=1 on the short instance.
    r_coeff_wr_en = 1'b1; r_coeff_addr = 2'd0; r_coeff_wr_data = 16'd3;
    tick();
    r_coeff_wr_en = 1'b0;
    run_r(16'd1, 16'd2, "round_pos3");
    run_r(16'hFFFF, 16'hFFFF, "round_neg3");

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
